// File: rtl/uart_sim_pkg.sv
// Shared simulation-side UART definitions plus the host character source and sink.
// The SystemVerilog bodies of uart_getchar/uart_putchar stand in for the host C routines.
package uart_sim_pkg;

  localparam logic [7:0] UART_NO_CHAR     = 8'hFF;
  localparam int         DPI_GETCHAR_NONE = -1;

  typedef enum logic {
    POLL_WAIT = 1'b0,
    POLL_CALL = 1'b1
  } uart_poll_state_e;

  // Scripted host stdin: queued results are returned in order, then "no char".
  int          getchar_script[$];
  int          getchar_calls;
  logic [7:0]  putchar_log[$];

  function automatic int uart_getchar();
    getchar_calls++;
    if (getchar_script.size() > 0) return getchar_script.pop_front();
    return DPI_GETCHAR_NONE;
  endfunction

  function automatic void uart_putchar(input logic [7:0] ch);
    putchar_log.push_back(ch);
  endfunction

endpackage

// File: rtl/uart_getchar_helper.sv
// Polls the host character source into a small FIFO and serves UART getchar pops from it.
// Optional echo of every popped byte to uart_putchar when UART_GETCHAR_ECHO_EN is defined.
module uart_getchar_helper
  import uart_sim_pkg::*;
#(
  parameter int  DEPTH         = 16,
  parameter int  POLL_INTERVAL = 1000,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          poll_en,
  input  logic          getchar_valid,
  output logic [7:0]    getchar_ch,
  output logic          rx_avail,
  output logic [CW-1:0] rx_count,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] POLL_RELOAD = TW'(POLL_INTERVAL - 1);

  typedef struct packed {
    uart_poll_state_e state;
    logic [TW-1:0]    timer;
    logic [PW-1:0]    wr_ptr;
  } poll_regs_t;

  typedef struct packed {
    poll_regs_t  regs;
    logic [7:0]  data;
  } poll_upd_t;

  logic [DEPTH-1:0][7:0] mem;
  poll_regs_t            pr;
  poll_regs_t            pr_next;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  poll_call;

  // One host call per poll edge: the returned byte, the write pointer and the
  // FSM state must all come from the same call, so they are produced together.
  function automatic poll_upd_t poll_host(input poll_regs_t cur);
    int        res;
    poll_upd_t upd;
    res = uart_getchar();
    upd.regs = cur;
    upd.data = UART_NO_CHAR;
    if (res >= 0 && res <= 255) begin
      upd.data        = res[7:0];
      upd.regs.wr_ptr = cur.wr_ptr + 1'b1;
    end else begin
      upd.regs.state  = POLL_WAIT;
      upd.regs.timer  = POLL_RELOAD;
    end
    return upd;
  endfunction

  assign wr_idx     = pr.wr_ptr[AW-1:0];
  assign empty      = (pr.wr_ptr == rd_ptr);
  assign full       = (pr.wr_ptr[AW] != rd_ptr[AW]) && (pr.wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = getchar_valid && !empty;
  assign poll_call  = (pr.state == POLL_CALL) && poll_en && !full;

  assign getchar_ch = empty ? UART_NO_CHAR : mem[rd_ptr[AW-1:0]];
  assign rx_avail   = !empty;
  assign rx_count   = CW'(pr.wr_ptr - rd_ptr);

  // Leaving WAIT one edge early puts the next call exactly POLL_INTERVAL edges after a miss.
  always_comb begin
    pr_next = pr;
    if (pr.state == POLL_WAIT && poll_en) begin
      if (pr.timer <= TW'(1)) begin
        pr_next.state = POLL_CALL;
        pr_next.timer = '0;
      end else begin
        pr_next.timer = pr.timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pr        <= '{state: POLL_WAIT, timer: POLL_RELOAD, wr_ptr: '0};
      rd_ptr    <= '0;
      mem       <= '0;
      underflow <= 1'b0;
    end else begin
      // On a miss the slot at wr_idx is free, so writing it is harmless.
      if (poll_call) begin
        {pr, mem[wr_idx]} <= poll_host(pr);
      end else begin
        pr <= pr_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef UART_GETCHAR_ECHO_EN
        uart_putchar(getchar_ch);
`endif
      end
      if (getchar_valid && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
